cache_memory: RTL and testbench

// - N-way set-associative, write-back, write-allocate data cache array with tag compare, LRU victim select and refill/writeback datapath.
// - Sits between the cache controller FSM, which drives the enables and memory handshake, and main memory.
// - Address split is {tag, index, blk_offset}, word-addressed.

---
 rtl/cache_memory.sv | 192 +++++++++++++++++++
 tb/tb_cache_memory.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/cache_memory.sv
// rtl/cache_memory.sv - N-way set-associative write-back data cache array with LRU victim select
//
// Purpose:
//   Tag/data storage for a write-back, write-allocate cache. Performs the tag
//   lookup, picks the victim way, and handles refill, CPU write and read. The
//   external controller FSM sequences the enables and the memory handshake.
//
// Ports:
//   clk              clock, rising edge
//   rst              synchronous active-high reset
//   tag/index/blk_offset   request address fields (word addressed)
//   req_type         0 = read, 1 = write
//   read_en_cache    lookup / read request
//   write_en_cache   CPU write, or refill when read_en_mem is also high
//   read_en_mem      memory is returning a line on data_in_mem
//   write_en_mem     controller is writing the victim back to memory
//   data_in_mem      refill line
//   data_in          CPU write word
//   dirty_block_out  victim line for writeback (registered)
//   hit              registered lookup result
//   data_out         registered read word
//   dirty_bit        victim is valid and dirty (registered)

module cache_memory #(
    parameter int WORD_SIZE         = 32,
    parameter int WORDS_PER_BLOCK   = 4,
    parameter int NUM_BLOCKS        = 64,
    parameter int NUM_WAYS          = 2,
    localparam int BLOCK_SIZE       = WORDS_PER_BLOCK * WORD_SIZE,
    localparam int NUM_SETS         = NUM_BLOCKS / NUM_WAYS,
    localparam int INDEX_WIDTH      = $clog2(NUM_SETS),
    localparam int OFFSET_WIDTH     = $clog2(WORDS_PER_BLOCK),
    localparam int TAG_WIDTH        = 32 - INDEX_WIDTH - OFFSET_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [TAG_WIDTH-1:0]    tag,
    input  logic [INDEX_WIDTH-1:0]  index,
    input  logic [OFFSET_WIDTH-1:0] blk_offset,
    input  logic                    req_type,
    input  logic                    read_en_cache,
    input  logic                    write_en_cache,
    input  logic                    read_en_mem,
    input  logic                    write_en_mem,
    input  logic [BLOCK_SIZE-1:0]   data_in_mem,
    input  logic [WORD_SIZE-1:0]    data_in,
    output logic [BLOCK_SIZE-1:0]   dirty_block_out,
    output logic                    hit,
    output logic [WORD_SIZE-1:0]    data_out,
    output logic                    dirty_bit
);

    // A single way still needs a 1-bit age / way-index signal to stay legal.
    localparam int AGE_W   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int WAY_W   = AGE_W;
    localparam int LINE_W  = BLOCK_SIZE + TAG_WIDTH + 2;
    localparam int TAG_LSB = 2;
    localparam int TAG_MSB = TAG_WIDTH + 1;

    // Line layout: {block, tag, dirty, valid}, valid at bit 0.
    logic [LINE_W-1:0] cache   [NUM_SETS][NUM_WAYS];
    logic [AGE_W-1:0]  lru_age [NUM_SETS][NUM_WAYS];

    logic                  lookup_hit;
    logic [WAY_W-1:0]      hit_way;
    logic                  inv_found;
    logic [WAY_W-1:0]      inv_way;
    logic [WAY_W-1:0]      lru_way;
    logic [AGE_W-1:0]      max_age;
    logic [WAY_W-1:0]      victim_way;
    logic [WAY_W-1:0]      touch_way;
    logic [AGE_W-1:0]      old_age;
    logic [AGE_W-1:0]      age_next [NUM_WAYS];
    logic [BLOCK_SIZE-1:0] hit_block;
    logic [BLOCK_SIZE-1:0] victim_block;
    logic                  victim_dirty;
    logic [WORD_SIZE-1:0]  hit_word;
    logic [BLOCK_SIZE-1:0] refill_block;
    logic [BLOCK_SIZE-1:0] wr_block;
    logic                  do_refill;

    assign do_refill = read_en_mem && write_en_cache;

    // Lookup and victim selection
    always_comb begin
        lookup_hit = 1'b0;
        hit_way    = '0;
        inv_found  = 1'b0;
        inv_way    = '0;
        lru_way    = '0;
        max_age    = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (cache[index][w][0] && (cache[index][w][TAG_MSB:TAG_LSB] == tag) && !lookup_hit) begin
                lookup_hit = 1'b1;
                hit_way    = WAY_W'(w);
            end
            if (!cache[index][w][0] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
            // Strict compare: among equally old ways the lowest index wins.
            if (lru_age[index][w] > max_age) begin
                max_age = lru_age[index][w];
                lru_way = WAY_W'(w);
            end
        end
        victim_way = inv_found ? inv_way : lru_way;
    end

    // Datapath for the selected lines
    always_comb begin
        hit_block    = cache[index][hit_way][LINE_W-1 -: BLOCK_SIZE];
        victim_block = cache[index][victim_way][LINE_W-1 -: BLOCK_SIZE];
        victim_dirty = cache[index][victim_way][0] && cache[index][victim_way][1];
        hit_word     = hit_block[blk_offset*WORD_SIZE +: WORD_SIZE];

        refill_block = data_in_mem;
        if (req_type) begin
            refill_block[blk_offset*WORD_SIZE +: WORD_SIZE] = data_in;
        end

        wr_block = hit_block;
        wr_block[blk_offset*WORD_SIZE +: WORD_SIZE] = data_in;
    end

    // LRU ages after touching one way: it becomes youngest, and every way
    // that was younger than it ages by one. Older ways keep their age.
    always_comb begin
        touch_way = do_refill ? victim_way : hit_way;
        old_age   = lru_age[index][touch_way];
        for (int v = 0; v < NUM_WAYS; v++) begin
            age_next[v] = lru_age[index][v];
            if (WAY_W'(v) == touch_way) begin
                age_next[v] = '0;
            end else if (lru_age[index][v] < old_age) begin
                age_next[v] = lru_age[index][v] + AGE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    cache[s][w][1:0] <= 2'b00;
                    lru_age[s][w]    <= '0;
                end
            end
            hit             <= 1'b0;
            data_out        <= '0;
            dirty_bit       <= 1'b0;
            dirty_block_out <= '0;
        end else if (do_refill) begin
            // Victim is recomputed here; tag/index must be held since the miss.
            cache[index][victim_way] <= {refill_block, tag, req_type, 1'b1};
            for (int v = 0; v < NUM_WAYS; v++) begin
                lru_age[index][v] <= age_next[v];
            end
            hit <= 1'b1;
        end else if (write_en_cache && req_type) begin
            if (lookup_hit) begin
                cache[index][hit_way] <= {wr_block, tag, 1'b1, 1'b1};
                for (int v = 0; v < NUM_WAYS; v++) begin
                    lru_age[index][v] <= age_next[v];
                end
                hit <= 1'b1;
            end else begin
                hit             <= 1'b0;
                dirty_bit       <= victim_dirty;
                dirty_block_out <= victim_block;
            end
        end else if (read_en_cache) begin
            hit <= lookup_hit;
            if (lookup_hit) begin
                data_out        <= hit_word;
                dirty_bit       <= 1'b0;
                dirty_block_out <= '0;
                for (int v = 0; v < NUM_WAYS; v++) begin
                    lru_age[index][v] <= age_next[v];
                end
            end else begin
                data_out        <= '0;
                dirty_bit       <= victim_dirty;
                dirty_block_out <= victim_block;
            end
        end else if (write_en_mem) begin
            // Writeback in progress: victim outputs stay stable for memory.
            hit <= hit;
        end
    end

endmodule

// File: tb/tb_cache_memory.sv
// tb/tb_cache_memory.sv - table-driven scoreboard bench for cache_memory

module tb_cache_memory;

    logic         clk;
    logic         rst;
    logic [24:0]  tag;
    logic [4:0]   index;
    logic [1:0]   blk_offset;
    logic         req_type;
    logic         read_en_cache;
    logic         write_en_cache;
    logic         read_en_mem;
    logic         write_en_mem;
    logic [127:0] data_in_mem;
    logic [31:0]  data_in;
    logic [127:0] dirty_block_out;
    logic         hit;
    logic [31:0]  data_out;
    logic         dirty_bit;

    cache_memory dut (
        .clk             (clk),
        .rst             (rst),
        .tag             (tag),
        .index           (index),
        .blk_offset      (blk_offset),
        .req_type        (req_type),
        .read_en_cache   (read_en_cache),
        .write_en_cache  (write_en_cache),
        .read_en_mem     (read_en_mem),
        .write_en_mem    (write_en_mem),
        .data_in_mem     (data_in_mem),
        .data_in         (data_in),
        .dirty_block_out (dirty_block_out),
        .hit             (hit),
        .data_out        (data_out),
        .dirty_bit       (dirty_bit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string        name;
        logic         rs, rd, wr, rmem, wmem, req;
        logic [24:0]  t;
        logic [4:0]   idx;
        logic [1:0]   off;
        logic [31:0]  din;
        logic [127:0] dmem;
        logic         e_hit;
        logic [31:0]  e_data;
        logic         e_dirty;
        logic         chk_dbo;
        logic [127:0] e_dbo;
    } vec_t;

    typedef struct {
        string        name;
        logic         e_hit;
        logic [31:0]  e_data;
        logic         e_dirty;
        logic         chk_dbo;
        logic [127:0] e_dbo;
    } exp_t;

    exp_t sb_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    localparam logic [127:0] B0   = 128'hDEADBEEF_55667788_11223344_AABBCCDD;
    localparam logic [127:0] B1   = 128'hFACEB00C_DEADC0DE_C0FFEE11_12345678;
    localparam logic [127:0] MEM1 = 128'hCAFEBABE_FEEDFACE_DEADBEAF_87654321;
    localparam logic [127:0] B0W  = 128'hDEADBEEF_55667788_11223344_0BADF00D;
    localparam logic [127:0] MEM2 = 128'h01010101_02020202_03030303_04040404;
    localparam logic [127:0] NEW2 = 128'h01010101_02020202_13572468_04040404;
    localparam logic [127:0] P5   = 128'h55550003_55550002_55550001_55550000;
    localparam logic [127:0] Q5   = 128'h66660003_66660002_66660001_66660000;

    function automatic vec_t mk(string name, logic rs, logic rd, logic wr, logic rmem,
                                logic wmem, logic req, logic [24:0] t, logic [4:0] idx,
                                logic [1:0] off, logic [31:0] din, logic [127:0] dmem,
                                logic e_hit, logic [31:0] e_data, logic e_dirty,
                                logic chk_dbo, logic [127:0] e_dbo);
        vec_t v;
        v.name = name; v.rs = rs; v.rd = rd; v.wr = wr; v.rmem = rmem; v.wmem = wmem;
        v.req = req; v.t = t; v.idx = idx; v.off = off; v.din = din; v.dmem = dmem;
        v.e_hit = e_hit; v.e_data = e_data; v.e_dirty = e_dirty;
        v.chk_dbo = chk_dbo; v.e_dbo = e_dbo;
        return v;
    endfunction

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step(input vec_t v);
        exp_t e;
        rst            = v.rs;
        read_en_cache  = v.rd;
        write_en_cache = v.wr;
        read_en_mem    = v.rmem;
        write_en_mem   = v.wmem;
        req_type       = v.req;
        tag            = v.t;
        index          = v.idx;
        blk_offset     = v.off;
        data_in        = v.din;
        data_in_mem    = v.dmem;
        e.name = v.name; e.e_hit = v.e_hit; e.e_data = v.e_data;
        e.e_dirty = v.e_dirty; e.chk_dbo = v.chk_dbo; e.e_dbo = v.e_dbo;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check({e.name, ".hit"},   128'(hit),       128'(e.e_hit));
        check({e.name, ".data"},  128'(data_out),  128'(e.e_data));
        check({e.name, ".dirty"}, 128'(dirty_bit), 128'(e.e_dirty));
        if (e.chk_dbo) check({e.name, ".dbo"}, dirty_block_out, e.e_dbo);
        rst = 1'b0; read_en_cache = 1'b0; write_en_cache = 1'b0;
        read_en_mem = 1'b0; write_en_mem = 1'b0;
    endtask

    vec_t tbl[$];

    initial begin
        rst = 1'b1; read_en_cache = 1'b0; write_en_cache = 1'b0; read_en_mem = 1'b0;
        write_en_mem = 1'b0; req_type = 1'b0; tag = '0; index = '0; blk_offset = '0;
        data_in = '0; data_in_mem = '0;

        // Reset state
        @(posedge clk); #1;
        step(mk("reset0", 1,0,0,0,0,0, 25'h0, 5'd0, 2'd0, 32'h0, 128'h0, 0, 32'h0, 0, 1, 128'h0));

        // Preload set 0 and make way1 the LRU way
        dut.cache[0][0] = {B0, 25'h1ABCDE, 1'b0, 1'b1};
        dut.cache[0][1] = {B1, 25'h00C0FF, 1'b0, 1'b1};
        dut.lru_age[0][0] = 1'b0;
        dut.lru_age[0][1] = 1'b1;

        //                 name          rs rd wr rm wm rq tag           idx   off   din            dmem   hit data          dirty chk dbo
        tbl.push_back(mk("rd_hit_w0",    0, 1,0,0,0,0, 25'h1ABCDE, 5'd0, 2'd2, 32'h0,        128'h0, 1, 32'h55667788, 0, 1, 128'h0));
        tbl.push_back(mk("rd_miss_cln",  0, 1,0,0,0,0, 25'h012345, 5'd0, 2'd0, 32'h0,        128'h0, 0, 32'h0,        0, 1, B1));
        tbl.push_back(mk("refill_w1",    0, 0,1,1,0,0, 25'h012345, 5'd0, 2'd0, 32'h0,        MEM1,   1, 32'h0,        0, 1, B1));
        tbl.push_back(mk("reread_off0",  0, 1,0,0,0,0, 25'h012345, 5'd0, 2'd0, 32'h0,        128'h0, 1, 32'h87654321, 0, 1, 128'h0));
        tbl.push_back(mk("rd_evicted",   0, 1,0,0,0,0, 25'h00C0FF, 5'd0, 2'd0, 32'h0,        128'h0, 0, 32'h0,        0, 1, B0));
        tbl.push_back(mk("wr_hit_w0",    0, 0,1,0,0,1, 25'h1ABCDE, 5'd0, 2'd0, 32'h0BADF00D, 128'h0, 1, 32'h0,        0, 1, B0));
        tbl.push_back(mk("rd_hit_w1",    0, 1,0,0,0,0, 25'h012345, 5'd0, 2'd3, 32'h0,        128'h0, 1, 32'hCAFEBABE, 0, 1, 128'h0));
        tbl.push_back(mk("miss_dirty",   0, 1,0,0,0,0, 25'h00C0FF, 5'd0, 2'd1, 32'h0,        128'h0, 0, 32'h0,        1, 1, B0W));
        tbl.push_back(mk("wb_hold",      0, 0,0,0,1,0, 25'h00C0FF, 5'd0, 2'd1, 32'h0,        128'h0, 0, 32'h0,        1, 1, B0W));
        tbl.push_back(mk("wr_miss",      0, 0,1,0,0,1, 25'h00AAAA, 5'd0, 2'd1, 32'h13572468, 128'h0, 0, 32'h0,        1, 1, B0W));
        tbl.push_back(mk("refill_wr",    0, 0,1,1,0,1, 25'h00AAAA, 5'd0, 2'd1, 32'h13572468, MEM2,   1, 32'h0,        1, 1, B0W));
        tbl.push_back(mk("rd_merged",    0, 1,0,0,0,0, 25'h00AAAA, 5'd0, 2'd1, 32'h0,        128'h0, 1, 32'h13572468, 0, 1, 128'h0));
        tbl.push_back(mk("rd_memword",   0, 1,0,0,0,0, 25'h00AAAA, 5'd0, 2'd2, 32'h0,        128'h0, 1, 32'h02020202, 0, 1, 128'h0));
        tbl.push_back(mk("rd_w1_off2",   0, 1,0,0,0,0, 25'h012345, 5'd0, 2'd2, 32'h0,        128'h0, 1, 32'hFEEDFACE, 0, 1, 128'h0));
        tbl.push_back(mk("miss_dirty2",  0, 1,0,0,0,0, 25'h1ABCDE, 5'd0, 2'd0, 32'h0,        128'h0, 0, 32'h0,        1, 1, NEW2));
        tbl.push_back(mk("idle_hold",    0, 0,0,0,0,0, 25'h0,      5'd0, 2'd0, 32'h0,        128'h0, 0, 32'h0,        1, 1, NEW2));

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // Reset after preload: outputs clear, previously valid lines miss
        step(mk("rst_again",     1, 0,0,0,0,0, 25'h0,      5'd0, 2'd0, 32'h0, 128'h0, 0, 32'h0, 0, 1, 128'h0));
        step(mk("post_rst_miss", 0, 1,0,0,0,0, 25'h1ABCDE, 5'd0, 2'd2, 32'h0, 128'h0, 0, 32'h0, 0, 0, 128'h0));
        step(mk("post_rst_miss2",0, 1,0,0,0,0, 25'h012345, 5'd0, 2'd0, 32'h0, 128'h0, 0, 32'h0, 0, 0, 128'h0));

        // All ways invalid: fills go to lowest invalid way
        step(mk("s5_miss",   0, 1,0,0,0,0, 25'h000777, 5'd5, 2'd0, 32'h0, 128'h0, 0, 32'h0, 0, 0, 128'h0));
        step(mk("s5_fill0",  0, 0,1,1,0,0, 25'h000777, 5'd5, 2'd0, 32'h0, P5,     1, 32'h0, 0, 0, 128'h0));
        check("s5_way0_valid", 128'(dut.cache[5][0][0]),    128'(1'b1));
        check("s5_way0_tag",   128'(dut.cache[5][0][26:2]), 128'(25'h000777));
        step(mk("s5_fill1",  0, 0,1,1,0,0, 25'h000888, 5'd5, 2'd0, 32'h0, Q5,     1, 32'h0, 0, 0, 128'h0));
        check("s5_way1_tag",   128'(dut.cache[5][1][26:2]), 128'(25'h000888));
        step(mk("s5_rd0",    0, 1,0,0,0,0, 25'h000777, 5'd5, 2'd3, 32'h0, 128'h0, 1, 32'h55550003, 0, 1, 128'h0));
        step(mk("s5_rd1",    0, 1,0,0,0,0, 25'h000888, 5'd5, 2'd1, 32'h0, 128'h0, 1, 32'h66660001, 0, 1, 128'h0));

        if (sb_q.size() != 0) begin
            n_total++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
